// File: rtl/gold_pkg.sv
// Shared types and Gold-code generator constants for the chip spreader.
// Tap masks list the polynomial terms below x^N (bit k set for each x^k term, bit 0 always set).
package gold_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SPREAD = 1'b1
    } gold_state_e;

    localparam int MAX_N = 10;

    // Preferred pairs: A = sparse m-sequence, B = its partner.
    localparam logic [MAX_N-1:0] TAPS_A_N5  = 10'h005;  // x5+x2+1
    localparam logic [MAX_N-1:0] TAPS_B_N5  = 10'h01D;  // x5+x4+x3+x2+1
    localparam logic [MAX_N-1:0] TAPS_A_N6  = 10'h003;  // x6+x+1
    localparam logic [MAX_N-1:0] TAPS_B_N6  = 10'h027;  // x6+x5+x2+x+1
    localparam logic [MAX_N-1:0] TAPS_A_N7  = 10'h009;  // x7+x3+1
    localparam logic [MAX_N-1:0] TAPS_B_N7  = 10'h00F;  // x7+x3+x2+x+1
    localparam logic [MAX_N-1:0] TAPS_A_N9  = 10'h011;  // x9+x4+1
    localparam logic [MAX_N-1:0] TAPS_B_N9  = 10'h059;  // x9+x6+x4+x3+1
    localparam logic [MAX_N-1:0] TAPS_A_N10 = 10'h009;  // x10+x3+1
    localparam logic [MAX_N-1:0] TAPS_B_N10 = 10'h10D;  // x10+x8+x3+x2+1

    function automatic bit legal_n(input int n);
        return (n == 5) || (n == 6) || (n == 7) || (n == 9) || (n == 10);
    endfunction

    function automatic logic [MAX_N-1:0] lookup_taps(input int n, input logic sel_b);
        logic [MAX_N-1:0] taps;
        taps = '0;
        case (n)
            5:       taps = sel_b ? TAPS_B_N5  : TAPS_A_N5;
            6:       taps = sel_b ? TAPS_B_N6  : TAPS_A_N6;
            7:       taps = sel_b ? TAPS_B_N7  : TAPS_A_N7;
            9:       taps = sel_b ? TAPS_B_N9  : TAPS_A_N9;
            10:      taps = sel_b ? TAPS_B_N10 : TAPS_A_N10;
            default: taps = '0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/axistream_if.sv
// Minimal AXI-Stream bundle: a word transfers on a cycle where tvalid and tready are both high;
// the master holds tdata/tvalid stable until that cycle, tready may change freely.
interface axistream_if #(
    parameter int DWIDTH = 13
) ();
    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/gold_lfsr.sv
// Fibonacci LFSR shifting right; bit 0 is the output, feedback enters at bit N-1.
// load has priority over advance so a reload on the last chip wins over the shift.
module gold_lfsr #(
    parameter int             N    = 5,
    parameter logic [N-1:0]   TAPS = '1
) (
    input  logic         s_axis_aclk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [N-1:0] seed,
    input  logic         advance,
    output logic [N-1:0] state
);

    logic feedback;

    assign feedback = ^(state & TAPS);

    always_ff @(posedge s_axis_aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= '0;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= {feedback, state[N-1:1]};
        end
    end

endmodule

// File: rtl/gold_spreader.sv
// Gold-code DSSS spreader: each data bit (LSB first) is XORed onto one full Gold code period,
// one chip per strobe cycle, with back-to-back words producing a gap-free chip stream.
module gold_spreader
    import gold_pkg::*;
#(
    parameter int SYS_CLK   = 100,
    parameter int N         = 5,
    parameter int DATA_BITS = 8
) (
    input  logic        s_axis_aclk,
    input  logic        aresetn,
    input  logic        strobe,
    axistream_if.slave  s_axis,
    output logic        phase_out,
    output logic        chip_valid,
    output logic        busy,
    output gold_state_e dbg_state
);

    localparam int L  = (1 << N) - 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [MAX_N-1:0] TAPS_A_ALL = lookup_taps(N, 1'b0);
    localparam logic [MAX_N-1:0] TAPS_B_ALL = lookup_taps(N, 1'b1);
    localparam logic [N-1:0]     TAPS_A     = TAPS_A_ALL[N-1:0];
    localparam logic [N-1:0]     TAPS_B     = TAPS_B_ALL[N-1:0];

    if (!legal_n(N)) begin : g_bad_n
        $error("gold_spreader: N=%0d unsupported (use 5, 6, 7, 9 or 10)", N);
    end
    if (DATA_BITS < 1 || DATA_BITS > 32) begin : g_bad_data_bits
        $error("gold_spreader: DATA_BITS=%0d outside 1..32", DATA_BITS);
    end
    if (SYS_CLK <= 0) begin : g_bad_sys_clk
        $error("gold_spreader: SYS_CLK=%0d must be positive", SYS_CLK);
    end

    gold_state_e          state, state_nxt;
    logic [N-1:0]         chip_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] data_q;
    logic [N-1:0]         idx_q;
    logic [N-1:0]         a_state, b_state;
    logic [N-1:0]         seed_b;
    logic                 advance, last_chip, last_bit, word_end;
    logic                 accept, reload, chip;

    assign advance   = (state == ST_SPREAD) && strobe;
    assign last_chip = (chip_cnt == N'(L - 1));
    assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));
    assign word_end  = advance && last_chip && last_bit;

    // Accept in IDLE, or on the very last chip so the next word follows without a gap.
    assign s_axis.tready = (state == ST_IDLE) || word_end;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign reload        = accept || (advance && last_chip);
    assign seed_b        = accept ? s_axis.tdata[N+DATA_BITS-1:DATA_BITS] : idx_q;

    // data_q shifts right at each bit boundary, so bit 0 is always the bit being spread.
    assign chip = a_state[0] ^ b_state[0] ^ data_q[0];

    gold_lfsr #(.N(N), .TAPS(TAPS_A)) u_lfsr_a (
        .s_axis_aclk (s_axis_aclk),
        .aresetn     (aresetn),
        .load        (reload),
        .seed        ({N{1'b1}}),
        .advance     (advance),
        .state       (a_state)
    );

    gold_lfsr #(.N(N), .TAPS(TAPS_B)) u_lfsr_b (
        .s_axis_aclk (s_axis_aclk),
        .aresetn     (aresetn),
        .load        (reload),
        .seed        (seed_b),
        .advance     (advance),
        .state       (b_state)
    );

    always_ff @(posedge s_axis_aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            chip_cnt   <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            phase_out  <= 1'b0;
            chip_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            chip_valid <= advance;
            if (advance) begin
                phase_out <= chip;
            end
            if (accept) begin
                data_q   <= s_axis.tdata[DATA_BITS-1:0];
                idx_q    <= s_axis.tdata[N+DATA_BITS-1:DATA_BITS];
                chip_cnt <= '0;
                bit_cnt  <= '0;
            end else if (advance) begin
                if (last_chip) begin
                    chip_cnt <= '0;
                    bit_cnt  <= bit_cnt + 1'b1;
                    data_q   <= data_q >> 1;
                end else begin
                    chip_cnt <= chip_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SPREAD;
            ST_SPREAD: if (word_end && !accept) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_SPREAD);
    assign dbg_state = state;

endmodule

// File: tb/tb_gold_spreader.sv
// Bench for gold_spreader (N=5, DATA_BITS=8): chip streams are compared against a
// sequence-level model built from the code polynomials' linear recurrences.
module tb_gold_spreader;
    import gold_pkg::*;

    localparam int N          = 5;
    localparam int DATA_BITS  = 8;
    localparam int L          = 31;
    localparam int W          = N + DATA_BITS;
    localparam int WORD_CHIPS = L * DATA_BITS;

    // Recurrence coefficients: s[n+5] = XOR of s[n+k] for each set bit k.
    localparam logic [N-1:0] POLY_A = 5'b00101;  // x^5 + x^2 + 1
    localparam logic [N-1:0] POLY_B = 5'b11101;  // x^5 + x^4 + x^3 + x^2 + 1

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strobe = 1'b0;
    logic        phase_out, chip_valid, busy;
    gold_state_e dbg_state;

    axistream_if #(.DWIDTH(W)) s_axis ();

    gold_spreader #(.SYS_CLK(100), .N(N), .DATA_BITS(DATA_BITS)) dut (
        .s_axis_aclk (clk),
        .aresetn     (rst_n),
        .strobe      (strobe),
        .s_axis      (s_axis),
        .phase_out   (phase_out),
        .chip_valid  (chip_valid),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    int         stamp_q[$];
    int         acc_cnt = 0;
    int         acc_cyc = 0;
    int         hold_err = 0;
    logic       last_phase = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (chip_valid) begin
                got_q.push_back(phase_out);
                stamp_q.push_back(cyc);
            end else if (phase_out !== last_phase) begin
                hold_err <= hold_err + 1;
            end
            if (s_axis.tvalid && s_axis.tready) begin
                acc_cnt <= acc_cnt + 1;
                acc_cyc <= cyc;
            end
        end
        last_phase <= phase_out;
    end

    // ---------------- reference model ----------------
    function automatic void m_seq(input logic [N-1:0] poly, input logic [N-1:0] seed,
                                  output logic [L-1:0] seq);
        logic s [0:L+N-1];
        logic t;
        for (int i = 0; i < N; i++) s[i] = seed[i];
        for (int n = 0; n < L; n++) begin
            t = 1'b0;
            for (int k = 0; k < N; k++) if (poly[k]) t = t ^ s[n+k];
            s[n+N] = t;
        end
        for (int i = 0; i < L; i++) seq[i] = s[i];
    endfunction

    function automatic void push_word(input logic [N-1:0] idx, input logic [DATA_BITS-1:0] data);
        logic [L-1:0] a, b;
        m_seq(POLY_A, {N{1'b1}}, a);
        m_seq(POLY_B, idx, b);
        for (int j = 0; j < DATA_BITS; j++)
            for (int c = 0; c < L; c++)
                exp_q.push_back(a[c] ^ b[c] ^ data[j]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        stamp_q.delete();
        acc_cnt  = 0;
        hold_err = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!s_axis.tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_axis.tready) begin
            errors++;
            $display("FAIL accept_timeout: tready=%b after %0d cycles, required 1", s_axis.tready, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] idx, input logic [DATA_BITS-1:0] data);
        s_axis.tdata  = {idx, data};
        s_axis.tvalid = 1'b1;
        wait_ready();
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = W'($urandom);  // must be ignored while not handshaking
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        strobe = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (phase_out !== 1'b0) begin errors++; $display("FAIL rst_phase: got %b, required 0", phase_out); end
        checks++; if (chip_valid !== 1'b0) begin errors++; $display("FAIL rst_chip_valid: got %b, required 0", chip_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b, required 1", s_axis.tready); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, ST_IDLE); end
        // strobe while idle must not produce chips
        clear_sb();
        strobe = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL idle_strobe_chips: got %0d chips, required 0", got_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_strobe_busy: got %b, required 0", busy); end
        strobe = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_m_sequence();
        clear_sb();
        strobe = 1'b1;
        push_word(5'd0, 8'h00);
        send_word(5'd0, 8'h00);
        wait_idle();
        checks++; if (got_q.size() != WORD_CHIPS) begin errors++; $display("FAIL mseq_count: got %0d chips, required %0d", got_q.size(), WORD_CHIPS); end
        checks++;
        if (stamp_q.size() == 0 || stamp_q[0] - acc_cyc != 2) begin
            errors++;
            $display("FAIL mseq_latency: got %0d cycles, required 2", stamp_q.size() == 0 ? -1 : stamp_q[0] - acc_cyc);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_q[i] !== 1'b1) begin errors++; $display("FAIL mseq_first_chips[%0d]: got %b, required 1", i, got_q[i]); end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mseq_chip[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
        end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL mseq_hold: got %0d phase changes without chip_valid, required 0", hold_err); end
    endtask

    task automatic test_data_inverse();
        logic [L-1:0] a;
        m_seq(POLY_A, {N{1'b1}}, a);
        clear_sb();
        strobe = 1'b1;
        send_word(5'd0, 8'h01);
        wait_idle();
        checks++; if (got_q.size() != WORD_CHIPS) begin errors++; $display("FAIL inv_count: got %0d chips, required %0d", got_q.size(), WORD_CHIPS); end
        for (int i = 0; i < L; i++) begin
            checks++;
            if (got_q[i] !== ~a[i]) begin errors++; $display("FAIL inv_bit0[%0d]: got %b, required %b", i, got_q[i], ~a[i]); end
            checks++;
            if (got_q[L+i] !== a[i]) begin errors++; $display("FAIL inv_bit1[%0d]: got %b, required %b", i, got_q[L+i], a[i]); end
        end
    endtask

    task automatic test_code_index();
        clear_sb();
        strobe = 1'b1;
        push_word(5'd1, 8'h00);
        send_word(5'd1, 8'h00);
        wait_idle();
        checks++; if (got_q[0] !== 1'b0) begin errors++; $display("FAIL idx1_chip0: got %b, required 0", got_q[0]); end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (got_q[i] !== 1'b1) begin errors++; $display("FAIL idx1_chip[%0d]: got %b, required 1", i, got_q[i]); end
        end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL idx1_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL idx1_stream[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_words();
        logic [N-1:0]         idx;
        logic [DATA_BITS-1:0] data;
        bit                   done;
        clear_sb();
        for (int w = 0; w < 4; w++) begin
            idx  = N'($urandom_range(0, 31));
            data = DATA_BITS'($urandom);
            push_word(idx, data);
            done = 1'b0;
            fork
                begin
                    send_word(idx, data);
                    wait_idle();
                    done = 1'b1;
                end
                begin
                    for (int i = 0; i < 8000 && !done; i++) begin
                        @(posedge clk);
                        #1;
                        strobe = 1'($urandom_range(0, 1));
                    end
                end
            join
        end
        strobe = 1'b0;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_stream[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
        end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL rand_hold: got %0d, required 0", hold_err); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]         idx1, idx2;
        logic [DATA_BITS-1:0] d1, d2;
        idx1 = N'($urandom_range(0, 31));
        idx2 = N'($urandom_range(0, 31));
        d1   = DATA_BITS'($urandom);
        d2   = DATA_BITS'($urandom);
        clear_sb();
        push_word(idx1, d1);
        push_word(idx2, d2);
        strobe = 1'b1;
        s_axis.tdata  = {idx1, d1};
        s_axis.tvalid = 1'b1;
        wait_ready();
        s_axis.tdata = {idx2, d2};
        wait_ready();
        s_axis.tvalid = 1'b0;
        wait_idle();
        checks++; if (got_q.size() != 2 * WORD_CHIPS) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), 2 * WORD_CHIPS); end
        checks++;
        if (stamp_q.size() == 0 || stamp_q[stamp_q.size()-1] - stamp_q[0] != 2 * WORD_CHIPS - 1) begin
            errors++;
            $display("FAIL b2b_gapless: got span %0d, required %0d",
                     stamp_q.size() == 0 ? -1 : stamp_q[stamp_q.size()-1] - stamp_q[0], 2 * WORD_CHIPS - 1);
        end
        checks++; if (acc_cnt != 2) begin errors++; $display("FAIL b2b_accepts: got %0d, required 2", acc_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_stream[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_strobe_toggle();
        logic [N-1:0]         idx;
        logic [DATA_BITS-1:0] data;
        int                   bad_gap;
        bit                   done;
        idx  = N'($urandom_range(0, 31));
        data = DATA_BITS'($urandom);
        clear_sb();
        push_word(idx, data);
        done = 1'b0;
        fork
            begin
                send_word(idx, data);
                wait_idle();
                done = 1'b1;
            end
            begin
                for (int i = 0; i < 4000 && !done; i++) begin
                    @(posedge clk);
                    #1;
                    strobe = ~strobe;
                end
            end
        join
        strobe = 1'b0;
        bad_gap = 0;
        for (int i = 1; i < stamp_q.size(); i++) if (stamp_q[i] - stamp_q[i-1] != 2) bad_gap++;
        checks++; if (got_q.size() != WORD_CHIPS) begin errors++; $display("FAIL toggle_count: got %0d, required %0d", got_q.size(), WORD_CHIPS); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL toggle_spacing: got %0d uneven gaps, required 0", bad_gap); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL toggle_hold: got %0d, required 0", hold_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_stream[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_word();
        int n;
        clear_sb();
        strobe = 1'b1;
        send_word(N'($urandom_range(1, 31)), 8'hA5);
        n = 0;
        while (got_q.size() < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (got_q.size() < 100) begin errors++; $display("FAIL midrst_reach: got %0d chips, required 100", got_q.size()); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (phase_out !== 1'b0) begin errors++; $display("FAIL midrst_phase: got %b, required 0", phase_out); end
        checks++; if (chip_valid !== 1'b0) begin errors++; $display("FAIL midrst_chip_valid: got %b, required 0", chip_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_leftover: got %0d chips, required 0", got_q.size()); end
        @(posedge clk);
        #1;
        push_word(5'd0, 8'h00);
        send_word(5'd0, 8'h00);
        wait_idle();
        checks++; if (got_q.size() != WORD_CHIPS) begin errors++; $display("FAIL midrst_count: got %0d, required %0d", got_q.size(), WORD_CHIPS); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_q[i] !== 1'b1) begin errors++; $display("FAIL midrst_restart[%0d]: got %b, required 1", i, got_q[i]); end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_stream[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        test_reset();
        test_m_sequence();
        test_data_inverse();
        test_code_index();
        test_random_words();
        test_back_to_back();
        test_strobe_toggle();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
